traffic_intersection_ctrl: RTL



---
 rtl/traffic_pkg.sv | 12 +
 rtl/traffic_phase_timer.sv | 17 +
 rtl/traffic_intersection_ctrl.sv | 86 ++++++++
 3 files changed

// File: rtl/traffic_pkg.sv
// traffic_pkg: state encoding shared by the intersection controller and its timer mux
package traffic_pkg;
    localparam int STATE_W = 3;
    localparam logic [STATE_W-1:0] AR_NS = 3'd0;
    localparam logic [STATE_W-1:0] NS_G  = 3'd1;
    localparam logic [STATE_W-1:0] NS_Y  = 3'd2;
    localparam logic [STATE_W-1:0] AR_EW = 3'd3;
    localparam logic [STATE_W-1:0] EW_G  = 3'd4;
    localparam logic [STATE_W-1:0] EW_Y  = 3'd5;
    localparam logic [STATE_W-1:0] PED   = 3'd6;
    localparam logic [STATE_W-1:0] FLASH = 3'd7;
endpackage

// File: rtl/traffic_phase_timer.sv
// traffic_phase_timer: phase counter that pulses expire on the last cycle of a phase
module traffic_phase_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic [W-1:0] limit,
    output logic         expire
);
    logic [W-1:0] count_q, count_d;
    assign expire = count_q == limit;
    always_comb count_d = (clr || expire) ? '0 : count_q + 1'b1;
    always_ff @(posedge clk)
        if (rst) count_q <= '0;
        else     count_q <= count_d;
endmodule

// File: rtl/traffic_intersection_ctrl.sv
// traffic_intersection_ctrl: two-road light sequencer with all-red clearance, walk phase and night flash
module traffic_intersection_ctrl
    import traffic_pkg::*;
#(
    parameter int TIMER_W       = 8,
    parameter int NS_GREEN_TIME = 20,
    parameter int EW_GREEN_TIME = 15,
    parameter int YELLOW_TIME   = 3,
    parameter int ALL_RED_TIME  = 2,
    parameter int PED_WALK_TIME = 10,
    parameter int FLASH_HALF    = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic ped_req,
    input  logic flash_mode,
    output logic ns_red,
    output logic ns_yellow,
    output logic ns_green,
    output logic ew_red,
    output logic ew_yellow,
    output logic ew_green,
    output logic walk,
    output logic ped_pending
);
    logic [STATE_W-1:0] state_q, state_d;
    logic               ped_q, ped_d, blink_q, blink_d;
    logic [TIMER_W-1:0] limit;
    logic               expire, clr;
    always_comb begin
        limit = TIMER_W'(ALL_RED_TIME - 1);
        case (state_q)
            NS_G:         limit = TIMER_W'(NS_GREEN_TIME - 1);
            EW_G:         limit = TIMER_W'(EW_GREEN_TIME - 1);
            NS_Y, EW_Y:   limit = TIMER_W'(YELLOW_TIME - 1);
            PED:          limit = TIMER_W'(PED_WALK_TIME - 1);
            FLASH:        limit = TIMER_W'(FLASH_HALF - 1);
            default:      limit = TIMER_W'(ALL_RED_TIME - 1);
        endcase
    end
    // flash exit is the only transition not aligned to a timer expiry, so it clears the timer itself
    assign clr = state_q == FLASH && !flash_mode;
    traffic_phase_timer #(.W(TIMER_W)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (clr),
        .limit  (limit),
        .expire (expire)
    );
    always_comb begin
        state_d = state_q;
        case (state_q)
            AR_NS:   state_d = expire ? (flash_mode ? FLASH : NS_G) : AR_NS;
            NS_G:    state_d = expire ? NS_Y : NS_G;
            NS_Y:    state_d = expire ? AR_EW : NS_Y;
            AR_EW:   state_d = expire ? EW_G : AR_EW;
            EW_G:    state_d = expire ? EW_Y : EW_G;
            EW_Y:    state_d = expire ? ((ped_q || ped_req) ? PED : AR_NS) : EW_Y;
            PED:     state_d = expire ? AR_NS : PED;
            FLASH:   state_d = flash_mode ? FLASH : AR_NS;
            default: state_d = AR_NS;
        endcase
    end
    always_comb begin
        ped_d   = (state_d == PED || state_q == PED) ? 1'b0 : ped_q | ped_req;
        blink_d = (state_d != FLASH) ? blink_q : (state_q != FLASH) ? 1'b1 : blink_q ^ expire;
    end
    always_ff @(posedge clk)
        if (rst) begin
            state_q <= AR_NS;
            ped_q   <= 1'b0;
            blink_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ped_q   <= ped_d;
            blink_q <= blink_d;
        end
    assign ns_red      = state_q inside {AR_NS, AR_EW, PED, EW_G, EW_Y};
    assign ns_yellow   = state_q == NS_Y || (state_q == FLASH && blink_q);
    assign ns_green    = state_q == NS_G;
    assign ew_red      = state_q inside {AR_NS, AR_EW, PED, NS_G, NS_Y} || (state_q == FLASH && blink_q);
    assign ew_yellow   = state_q == EW_Y;
    assign ew_green    = state_q == EW_G;
    assign walk        = state_q == PED;
    assign ped_pending = ped_q;
endmodule
